prio_grant_ctrl: RTL and testbench
==================================

Name: prio_grant_ctrl

Overview:
- Registered grant controller on the consumer side of the N-source priority arbiter tree.
- Samples the arbiter's combinational winner (req, sel, prio), issues a held one-hot grant to the winning source, and waits for that source to signal completion before re-arbitrating.
- Optionally asks the current holder to yield when a strictly higher-priority request appears (priority 0 is highest).
- Optionally revokes a grant held too long.

Parameters:
- N, 8, number of sources; power of two, >= 2
- PRIO_BITS, 3, priority field width
- PREEMPT, 1, 1 = enable the preempt_o yield request; 0 = preempt_o tied low
- MAX_HOLD, 64, maximum cycles a grant may be held; 0 disables the timeout
- HOLD_W, 16, hold counter width; MAX_HOLD must be < 2^HOLD_W

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- arb_req_i  in  1  arbiter output request (any source requesting)
- arb_sel_i  in  $clog2(N)  arbiter winning source index
- arb_prio_i  in  PRIO_BITS  arbiter winning priority
- done_i  in  N  per-source release pulse; only bit gnt_sel_o is honoured
- gnt_o  out  N  one-hot grant, registered
- gnt_valid_o  out  1  OR of gnt_o
- gnt_sel_o  out  $clog2(N)  index of the granted source
- gnt_prio_o  out  PRIO_BITS  priority latched at grant
- preempt_o  out  1  yield request to the current holder
- timeout_o  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset: clk_i and rst_i are the only clock and reset. Reset is synchronous and active-high. When rst_i is sampled high:
  - state=IDLE
  - gnt_o=0, gnt_valid_o=0, gnt_sel_o=0, gnt_prio_o=0
  - preempt_o=0, timeout_o=0, hold counter=0
  - rst_i mid-grant drops the grant on the next edge; no timeout_o pulse.
- States: IDLE, GRANT, GAP.
- IDLE: when arb_req_i=1, latch arb_sel_i and arb_prio_i and go to GRANT. gnt_o[arb_sel_i] is high from the next cycle (1-cycle latency from arb_req_i).
- GRANT:
  - gnt_o, gnt_sel_o and gnt_prio_o are held constant regardless of arbiter changes.
  - The hold counter increments each GRANT cycle, starting at 1 in the first GRANT cycle.
- Release: done_i[gnt_sel_o]=1 in GRANT causes:
  - next cycle: gnt_o=0, preempt_o=0, go to GAP.
  - done_i bits for other sources are ignored.
  - done_i in IDLE or GAP is ignored.
- GAP: exactly one cycle with gnt_o=0, then IDLE. This guarantees at least one dead cycle between grants, even back-to-back to the same source.
- Preemption (PREEMPT=1):
  - Condition, evaluated each GRANT cycle: arb_req_i=1 and arb_prio_i < gnt_prio_o (strict, unsigned).
  - When met, preempt_o is set on the next edge and stays set until the grant ends.
  - The grant is not forcibly removed; the holder must assert done.
  - Equal priority never preempts.
- Timeout (MAX_HOLD>0):
  - If the counter equals MAX_HOLD and done is not asserted that cycle, then next cycle: gnt_o=0, timeout_o=1 for one cycle, go to GAP.
  - done and the timeout condition in the same cycle: done wins, no timeout_o.
- Invariants: gnt_o is zero or one-hot; gnt_valid_o == |gnt_o; preempt_o implies gnt_valid_o.
- arb_req_i dropping during GRANT has no effect.

Test Plan:
- Basic grant: arb_req_i=1, sel=5, prio=3 for 1 cycle in IDLE -> next cycle gnt_o=8'b0010_0000, gnt_prio_o=3. done_i[5] pulse -> gnt_o=0 next cycle, one GAP cycle, re-grant no earlier than 2 cycles after done.
- Wrong done: grant on sel=2, pulse done_i[4] -> grant held. Then done_i[2] -> released.
- Preempt: hold sel=1 at prio=4, arbiter presents prio=4 -> preempt_o stays 0. Arbiter presents prio=2 -> preempt_o=1 next cycle and held until done_i[1]; gnt_o unchanged until then.
- Timeout: MAX_HOLD=4, grant with no done -> gnt_o high exactly 4 cycles, then gnt_o=0 with timeout_o=1 for 1 cycle. Repeat with done_i in cycle 4 -> no timeout_o.
- Reset mid-grant: rst_i=1 during GRANT with preempt_o=1 -> all outputs 0 next edge, state IDLE; first grant after reset appears 1 cycle after arb_req_i.
- Random: N=8, random requests/dones, MAX_HOLD=16, PREEMPT=1 -> one-hot invariant, no back-to-back grants without GAP, every timeout_o preceded by 16 GRANT cycles.

Source files
------------

// File: rtl/prio_grant_ctrl.sv
// rtl/prio_grant_ctrl.sv - registered one-hot grant controller behind a priority arbiter tree
// Holds the sampled winner until it releases, with optional yield request and hold timeout.
module prio_grant_ctrl #(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    parameter int PREEMPT   = 1,
    parameter int MAX_HOLD  = 64,
    parameter int HOLD_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arb_req_i,
    input  logic [$clog2(N)-1:0] arb_sel_i,
    input  logic [PRIO_BITS-1:0] arb_prio_i,
    input  logic [N-1:0]         done_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_sel_o,
    output logic [PRIO_BITS-1:0] gnt_prio_o,
    output logic                 preempt_o,
    output logic                 timeout_o
);

    localparam int SEL_W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state_q;
    logic [N-1:0]         gnt_q;
    logic [SEL_W-1:0]     sel_q;
    logic [PRIO_BITS-1:0] prio_q;
    logic                 preempt_q;
    logic                 timeout_q;
    logic [HOLD_W-1:0]    cnt_q;

    logic holder_done;
    logic hold_expired;
    logic higher_waiting;

    assign holder_done    = done_i[sel_q];
    assign hold_expired   = (MAX_HOLD > 0) && (cnt_q == HOLD_W'(MAX_HOLD));
    assign higher_waiting = (PREEMPT != 0) && arb_req_i && (arb_prio_i < prio_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            prio_q    <= '0;
            preempt_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_req_i) begin
                        state_q   <= GRANT;
                        gnt_q     <= ONE << arb_sel_i;
                        sel_q     <= arb_sel_i;
                        prio_q    <= arb_prio_i;
                        preempt_q <= 1'b0;
                        cnt_q     <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    // Release takes precedence over an expiring hold in the same cycle.
                    if (holder_done) begin
                        state_q   <= GAP;
                        gnt_q     <= '0;
                        preempt_q <= 1'b0;
                        cnt_q     <= '0;
                    end else if (hold_expired) begin
                        state_q   <= GAP;
                        gnt_q     <= '0;
                        preempt_q <= 1'b0;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + HOLD_W'(1);
                        if (higher_waiting) begin
                            preempt_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = |gnt_q;
    assign gnt_sel_o   = sel_q;
    assign gnt_prio_o  = prio_q;
    assign preempt_o   = preempt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_prio_grant_ctrl.sv
// tb/tb_prio_grant_ctrl.sv - directed and randomized self-checking bench for prio_grant_ctrl
module tb_prio_grant_ctrl;

    localparam int N        = 8;
    localparam int PB       = 3;
    localparam int MAX_HOLD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          arb_req;
    logic [2:0]    arb_sel;
    logic [PB-1:0] arb_prio;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [2:0]    gnt_sel;
    logic [PB-1:0] gnt_prio;
    logic          preempt;
    logic          timeout;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: who holds the bus, for how long, and what the outputs should read.
    int m_owner    = -1;
    int m_age      = 0;
    bit m_gap      = 0;
    bit m_pre      = 0;
    bit m_to       = 0;
    int m_sel_last = 0;
    int m_pri_last = 0;

    int run_len    = 0;
    logic [N-1:0] prev_gnt = '0;

    prio_grant_ctrl #(
        .N(N), .PRIO_BITS(PB), .PREEMPT(1), .MAX_HOLD(MAX_HOLD), .HOLD_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .arb_req_i(arb_req), .arb_sel_i(arb_sel),
        .arb_prio_i(arb_prio), .done_i(done), .gnt_o(gnt), .gnt_valid_o(gnt_valid),
        .gnt_sel_o(gnt_sel), .gnt_prio_o(gnt_prio), .preempt_o(preempt), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit req, input int sel, input int pri, input logic [N-1:0] dn);
        if (r) begin
            m_owner = -1; m_age = 0; m_gap = 0; m_pre = 0; m_to = 0;
            m_sel_last = 0; m_pri_last = 0;
            return;
        end
        m_to = 0;
        if (m_owner >= 0) begin
            if (dn[m_owner]) begin
                m_owner = -1; m_gap = 1; m_pre = 0;
            end else if (m_age == MAX_HOLD) begin
                m_owner = -1; m_gap = 1; m_pre = 0; m_to = 1;
            end else begin
                m_age++;
                if (req && pri < m_pri_last) m_pre = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (req) begin
            m_owner = sel; m_sel_last = sel; m_pri_last = pri; m_age = 1; m_pre = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit req, input int sel, input int pri, input logic [N-1:0] dn);
        logic [N-1:0] exp_gnt;
        rst = r; arb_req = req; arb_sel = 3'(sel); arb_prio = PB'(pri); done = dn;
        model_step(r, req, sel, pri, dn);
        @(posedge clk);
        #1;
        exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("gnt_sel", 32'(gnt_sel), 32'(m_sel_last));
        check("gnt_prio", 32'(gnt_prio), 32'(m_pri_last));
        check("preempt", 32'(preempt), 32'(m_pre));
        check("timeout", 32'(timeout), 32'(m_to));
        check("onehot", 32'($countones(gnt) <= 1), 32'd1);
        check("preempt_implies_valid", 32'(!preempt || gnt_valid), 32'd1);
        if (prev_gnt != '0 && gnt != '0)
            check("no_back_to_back", 32'(gnt), 32'(prev_gnt));
        if (timeout)
            check("timeout_hold_len", 32'(run_len), 32'(MAX_HOLD));
        run_len  = gnt_valid ? run_len + 1 : 0;
        prev_gnt = gnt;
    endtask

    initial begin
        rst = 1'b1; arb_req = 1'b0; arb_sel = '0; arb_prio = '0; done = '0;
        @(posedge clk); #1;
        cycle(1, 1, 5, 3, 8'hFF);
        check("reset_gnt", 32'(gnt), 32'd0);

        // Basic grant, release, gap, re-grant to the same source.
        cycle(0, 1, 5, 3, 8'h00);
        check("basic_gnt", 32'(gnt), 32'h20);
        check("basic_prio", 32'(gnt_prio), 32'd3);
        cycle(0, 1, 1, 0, 8'h00);
        check("basic_hold", 32'(gnt), 32'h20);
        cycle(0, 1, 5, 3, 8'h20);
        check("basic_release", 32'(gnt), 32'd0);
        cycle(0, 1, 5, 3, 8'h00);
        check("basic_gap", 32'(gnt), 32'd0);
        cycle(0, 1, 5, 3, 8'h00);
        check("basic_regrant", 32'(gnt), 32'h20);
        cycle(0, 0, 0, 0, 8'h20);
        cycle(0, 0, 0, 0, 8'h00);

        // Done from a non-holder is ignored.
        cycle(0, 1, 2, 6, 8'h00);
        cycle(0, 0, 0, 0, 8'h10);
        check("wrong_done_held", 32'(gnt), 32'h04);
        cycle(0, 0, 0, 0, 8'h04);
        check("right_done_released", 32'(gnt), 32'd0);
        cycle(0, 0, 0, 0, 8'h00);

        // Equal priority never preempts; strictly higher does and sticks.
        cycle(0, 1, 1, 4, 8'h00);
        cycle(0, 1, 3, 4, 8'h00);
        check("equal_prio_no_preempt", 32'(preempt), 32'd0);
        cycle(0, 1, 3, 2, 8'h00);
        check("preempt_set", 32'(preempt), 32'd1);
        cycle(0, 0, 0, 0, 8'h00);
        check("preempt_held", 32'(preempt), 32'd1);
        check("preempt_gnt_kept", 32'(gnt), 32'h02);
        cycle(0, 0, 0, 0, 8'h02);
        check("preempt_cleared", 32'(preempt), 32'd0);
        cycle(0, 0, 0, 0, 8'h00);

        // Timeout after exactly MAX_HOLD grant cycles.
        cycle(0, 1, 6, 1, 8'h00);
        for (int i = 1; i < MAX_HOLD; i++) cycle(0, 0, 0, 0, 8'h00);
        check("timeout_last_gnt", 32'(gnt), 32'h40);
        cycle(0, 0, 0, 0, 8'h00);
        check("timeout_pulse", 32'(timeout), 32'd1);
        check("timeout_gnt_dropped", 32'(gnt), 32'd0);
        cycle(0, 0, 0, 0, 8'h00);
        check("timeout_one_cycle", 32'(timeout), 32'd0);

        // Done on the expiring cycle wins over the timeout.
        cycle(0, 1, 6, 1, 8'h00);
        for (int i = 1; i < MAX_HOLD; i++) cycle(0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h40);
        check("done_beats_timeout", 32'(timeout), 32'd0);
        cycle(0, 0, 0, 0, 8'h00);

        // Reset mid-grant with a pending yield request.
        cycle(0, 1, 0, 5, 8'h00);
        cycle(0, 1, 4, 1, 8'h00);
        check("pre_reset_preempt", 32'(preempt), 32'd1);
        cycle(1, 1, 4, 1, 8'h00);
        check("reset_mid_gnt", 32'(gnt), 32'd0);
        check("reset_mid_preempt", 32'(preempt), 32'd0);
        check("reset_mid_timeout", 32'(timeout), 32'd0);
        cycle(0, 1, 3, 2, 8'h00);
        check("post_reset_grant", 32'(gnt), 32'h08);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [N-1:0] dn;
            dn = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            cycle(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)), dn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
